// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined Kogge-Stone adder.
package adder_pkg;

    typedef enum logic [1:0] {
        KILL = 2'b00,
        PROP = 2'b01,
        GEN  = 2'b11
    } kpg_t;

    function automatic int calc_levels(input int width);
        return $clog2(width);
    endfunction

    function automatic kpg_t kpg_of(input logic op_a, input logic op_b);
        if (op_a & op_b) return GEN;
        if (op_a ^ op_b) return PROP;
        return KILL;
    endfunction

endpackage

// File: rtl/kpg_merge.sv
// One prefix node: a resolved upper group dominates, a propagating one defers to the lower group.
module kpg_merge
    import adder_pkg::*;
(
    input  kpg_t i_upper,
    input  kpg_t i_lower,
    output kpg_t o_merged
);

    assign o_merged = (i_upper == PROP) ? i_lower : i_upper;

endmodule

// File: rtl/pipe_prefix_adder.sv
// Pipelined Kogge-Stone adder/subtractor: one register stage for kpg seeding, one per prefix level,
// with a global valid/ready stall.
module pipe_prefix_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);

    localparam int LEVELS = calc_levels(WIDTH);

    logic              w_adv;
    logic [LEVELS:0]   r_vld_pipe;
    logic [WIDTH-1:0]  r_a [LEVELS+1];
    logic [WIDTH-1:0]  r_b [LEVELS+1];
    kpg_t              r_pref [LEVELS+1][WIDTH+1];
    kpg_t              w_seed [WIDTH+1];
    kpg_t              w_lvl  [LEVELS][WIDTH+1];
    logic [WIDTH-1:0]  w_b_eff;
    logic              w_cin_eff;
    kpg_t              w_top;
    logic [WIDTH:0]    w_carry;

    assign w_adv     = !r_vld_pipe[LEVELS] || out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_vld_pipe[LEVELS];

    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub | cin;

    // Position 0 holds the carry-in; position i+1 describes operand bit i.
    always_comb begin
        w_seed[0] = w_cin_eff ? GEN : KILL;
        for (int i = 0; i < WIDTH; i++) begin
            w_seed[i+1] = kpg_of(a[i], w_b_eff[i]);
        end
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        for (genvar i = 0; i <= WIDTH; i++) begin : g_pos
            if (i >= (1 << k)) begin : g_node
                kpg_merge u_merge (
                    .i_upper  (r_pref[k][i]),
                    .i_lower  (r_pref[k][i-(1<<k)]),
                    .o_merged (w_lvl[k][i])
                );
            end else begin : g_pass
                assign w_lvl[k][i] = r_pref[k][i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_pipe <= '0;
            for (int s = 0; s <= LEVELS; s++) begin
                r_a[s] <= '0;
                r_b[s] <= '0;
                for (int i = 0; i <= WIDTH; i++) begin
                    r_pref[s][i] <= KILL;
                end
            end
        end else if (w_adv) begin
            r_vld_pipe <= {r_vld_pipe[LEVELS-1:0], in_valid};
            r_a[0]     <= a;
            r_b[0]     <= w_b_eff;
            r_pref[0]  <= w_seed;
            for (int s = 1; s <= LEVELS; s++) begin
                r_a[s]    <= r_a[s-1];
                r_b[s]    <= r_b[s-1];
                r_pref[s] <= w_lvl[s-1];
            end
        end
    end

    // The top position spans bits [WIDTH:1] only after LEVELS levels; fold in the carry-in
    // position so an all-propagate operand still yields the right carry-out.
    kpg_merge u_cout (
        .i_upper  (r_pref[LEVELS][WIDTH]),
        .i_lower  (r_pref[LEVELS][0]),
        .o_merged (w_top)
    );

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_carry[i] = r_pref[LEVELS][i][1];
        end
        w_carry[WIDTH] = w_top[1];
    end

    assign sum = {w_carry[WIDTH], r_a[LEVELS] ^ r_b[LEVELS] ^ w_carry[WIDTH-1:0]};
    assign ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

endmodule

// File: tb/tb_pipe_prefix_adder.sv
// Directed and streaming checks for pipe_prefix_adder at WIDTH=16.
module tb_pipe_prefix_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        cin, sub;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] sum;
    logic        ovf;

    pipe_prefix_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc_n = 0;
    int          n_cons = 0;
    int          first_cons = 0;
    int          last_cons = 0;
    logic        acc, cons, saw_vld, rdy_s;
    logic        hold_chk = 1'b0;
    logic [17:0] held;
    logic [17:0] cur_exp;
    logic [17:0] q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Independent reference: widened add plus sign-rule overflow.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mcin, input logic msub);
        logic [15:0] be;
        logic [16:0] s;
        logic        ov;
        be = msub ? ~mb : mb;
        s  = {1'b0, ma} + {1'b0, be} + {16'd0, (msub ? 1'b1 : mcin)};
        ov = (ma[15] == be[15]) && (s[15] != ma[15]);
        return {ov, s};
    endfunction

    task automatic drive(input logic [15:0] da, input logic [15:0] db, input logic dcin,
                         input logic dsub, input logic [17:0] exp);
        in_valid = 1'b1;
        a = da; b = db; cin = dcin; sub = dsub;
        cur_exp = exp;
    endtask

    // One clock: sample handshakes at the falling edge, score results, then pass the rising edge.
    task automatic cyc();
        logic [17:0] e;
        @(negedge clk);
        acc     = in_valid && in_ready;
        cons    = out_valid && out_ready;
        saw_vld = out_valid;
        rdy_s   = in_ready;
        if (hold_chk) chk("hold", {14'd0, ovf, sum}, {14'd0, held});
        if (cons) begin
            if (q.size() == 0) chk("spurious", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk("sum", {15'd0, sum}, {15'd0, e[16:0]});
                chk("ovf", {31'd0, ovf}, {31'd0, e[17]});
            end
            if (n_cons == 0) first_cons = cyc_n;
            last_cons = cyc_n;
            n_cons++;
        end
        if (acc) q.push_back(cur_exp);
        hold_chk = out_valid && !out_ready;
        held     = {ovf, sum};
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic lat_beat(input string tag, input logic [15:0] da, input logic [15:0] db,
                            input logic dcin, input logic dsub, input logic [17:0] exp);
        int n;
        out_ready = 1'b1;
        drive(da, db, dcin, dsub, exp);
        cyc();
        chk({tag, "_acc"}, {31'd0, acc}, 32'd1);
        in_valid = 1'b0;
        n = 1;
        while (n < 20) begin
            cyc();
            if (saw_vld) break;
            n++;
        end
        chk({tag, "_lat"}, n, 32'd5);
        chk({tag, "_empty"}, q.size(), 32'd0);
    endtask

    task automatic stream(input string tag, input int nbeats, input int st_at, input int st_len);
        logic [15:0] ra, rb;
        logic        rc, rs;
        int          idx, t;
        idx = 0; t = 0; n_cons = 0;
        ra = 16'($urandom); rb = 16'($urandom);
        rc = 1'($urandom); rs = 1'($urandom);
        while (idx < nbeats && t < nbeats + 60) begin
            out_ready = !(t >= st_at && t < st_at + st_len);
            drive(ra, rb, rc, rs, model(ra, rb, rc, rs));
            cyc();
            if (!out_ready) chk({tag, "_rdy"}, {31'd0, rdy_s}, 32'd0);
            if (acc) begin
                idx++;
                ra = 16'($urandom); rb = 16'($urandom);
                rc = 1'($urandom); rs = 1'($urandom);
            end
            t++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) cyc();
        chk({tag, "_drain"}, q.size(), 32'd0);
        chk({tag, "_cnt"}, n_cons, nbeats);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0; cur_exp = '0;
        #12;
        chk("rst_vld", {31'd0, out_valid}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("rst_sum", {15'd0, sum}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;

        lat_beat("ripple",   16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h1_0000);
        lat_beat("sub_brw",  16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0_FFFE);
        lat_beat("sub_nb",   16'h0007, 16'h0005, 1'b0, 1'b1, 18'h1_0002);
        lat_beat("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h2_8000);
        lat_beat("ovf_neg",  16'h8000, 16'hFFFF, 1'b0, 1'b0, 18'h3_7FFF);
        lat_beat("allprop",  16'hFFFF, 16'h0000, 1'b1, 1'b0, 18'h1_0000);
        lat_beat("sub_zero", 16'h0000, 16'h0000, 1'b0, 1'b1, 18'h1_0000);
        lat_beat("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 18'h3_7FFF);
        lat_beat("add_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 18'h0_5556);
        lat_beat("sub_cin",  16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0_FFFE);

        stream("tput", 100, -100, 0);
        chk("tput_span", last_cons - first_cons, 32'd99);

        stream("bp", 30, 10, 7);

        // Reset with three beats in flight, the oldest already presented.
        out_ready = 1'b1;
        drive(16'h0001, 16'h0001, 1'b0, 1'b0, 18'h0_0002); cyc();
        drive(16'h0002, 16'h0002, 1'b0, 1'b0, 18'h0_0004); cyc();
        drive(16'h0003, 16'h0003, 1'b0, 1'b0, 18'h0_0006); cyc();
        in_valid = 1'b0;
        cyc();
        out_ready = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_sum", {15'd0, sum}, 32'd0);
        q.delete();
        hold_chk = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        n_cons = 0;
        repeat (8) cyc();
        chk("stale", n_cons, 32'd0);
        lat_beat("after_rst", 16'h00FF, 16'h0F01, 1'b0, 1'b0, 18'h0_1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
